hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage core; sits beside the decode stage.
- Tracks in-flight register destinations (EX/MEM/WB) in a shadow scoreboard.
- Detects RAW hazards against the registers decode is reading and generates stall, bubble and flush controls for the PC, IF/ID and ID/EX registers.
- Freezes the pipe on memory stalls and sequences halt drain.

Parameters:
- REG_W, 3, register-select width (8 architectural registers, no hardwired zero).
- CNT_W, 16, width of the saturating hazard-stall counter.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset (rst==0 resets).
- id_valid  in  1  decode holds a real instruction.
- id_rs  in  REG_W  first source (instr[10:8]).
- id_rs_used  in  1  instruction reads id_rs.
- id_rt  in  REG_W  second source (instr[7:5]).
- id_rt_used  in  1  instruction reads id_rt.
- id_wr_en  in  1  decoded RegWrite.
- id_wr_reg  in  REG_W  decoded write-register select (includes JAL->r7).
- id_is_load  in  1  decoded MemRead.
- id_is_halt  in  1  decoded halt.
- redirect  in  1  taken branch/jump resolved in EX this cycle.
- mem_stall  in  1  data/instruction memory stall.
- mem_done  in  1  memory access completed.
- pc_en  out  1  PC write enable.
- ifid_en  out  1  IF/ID register enable.
- ifid_flush  out  1  IF/ID loads a NOP.
- idex_bubble  out  1  ID/EX loads a NOP.
- pipe_adv  out  1  EX/MEM and MEM/WB register enable.
- halted  out  1  core fully halted.
- hazard_cnt  out  CNT_W  cycles lost to RAW stalls.

Behaviour:
- Scoreboard: three slots (EX, MEM, WB), each {v, reg, ld}.
  - On pipe_adv: WB<=MEM, MEM<=EX, EX<=(issue ? {id_wr_en, id_wr_reg, id_is_load} : 0).
  - issue = state RUN & id_valid & ~hazard & ~redirect & ~mem_stall.
- match(r) = (EX.v & EX.reg==r) | (MEM.v & MEM.reg==r).
  - WB is never a hazard; the register file bypasses same-cycle writes.
- hazard = id_valid & ((id_rs_used & match(id_rs)) | (id_rt_used & match(id_rt))).
- States: RUN, MEMWAIT, DRAIN, HALTED.
- RUN outputs, in priority order:
  - mem_stall=1: all enables 0 and flush/bubble 0 in that cycle, same cycle. Next state MEMWAIT.
  - else redirect=1: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1, pipe_adv=1.
  - else hazard=1: pc_en=0, ifid_en=0, idex_bubble=1, pipe_adv=1. hazard_cnt++ (saturates at all-ones).
  - else: pc_en=ifid_en=pipe_adv=1, flush=bubble=0.
  - Issuing with id_is_halt=1 -> DRAIN.
- MEMWAIT:
  - All enables 0; scoreboard frozen.
  - Return to RUN on mem_done & ~mem_stall; outputs in that cycle are as in RUN.
- DRAIN:
  - pc_en=ifid_en=0; idex_bubble=1; pipe_adv=1 (mem_stall still freezes it).
  - -> HALTED when EX, MEM and WB are all invalid and no stall is pending. This takes 3 advancing cycles after the halt issues.
- HALTED: all enables 0, halted=1. Sticky until reset.
- Redirect in DRAIN is ignored (halt is older).
- Reset, asynchronous, may occur mid-stall or mid-drain:
  - Slots invalid, state RUN, hazard_cnt=0, halted=0.
  - Combinational outputs follow RUN with an empty scoreboard: pc_en=ifid_en=pipe_adv=1, ifid_flush=idex_bubble=0.

Optional Feature:
- FORWARD_EN.
- Defined: the EX stage has forwarding from EX/MEM and MEM/WB. match(r) becomes EX.v & EX.ld & EX.reg==r (load-use only), so a load-use costs exactly 1 stall cycle.
- Undefined: full scoreboard match as above, so a dependency costs 2 stall cycles on the EX producer, 1 on MEM.

Test Plan:
- Independent ADDs r1<-r2+r3 then r4<-r5+r6 -> no stall; pc_en=1 every cycle; hazard_cnt=0.
- ADD r1 then SUB r2<-r1-r3, no FORWARD_EN -> pc_en=0 and idex_bubble=1 for 2 cycles; hazard_cnt=2. With FORWARD_EN -> 0 stalls.
- LD r1 then ADD r2<-r1+r1 with FORWARD_EN -> exactly 1 bubble; hazard_cnt=1.
- Hazard and redirect in the same cycle -> ifid_flush=1, idex_bubble=1, pc_en=1; hazard_cnt unchanged.
- mem_stall held 4 cycles during a RAW stall -> all enables 0 for 4 cycles; scoreboard unchanged. After mem_done, the remaining stall cycles complete.
- HALT issue -> halted=1 exactly 3 cycles after the DRAIN entry edge. Assert rst=0 during DRAIN -> halted=0 immediately and slots cleared.

Source files
------------

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - RAW scoreboard, stall/flush sequencing and halt drain for the 5-stage core
// Build option FORWARD_EN: EX-stage forwarding present, only load-use stalls.
module hazard_ctrl #(
  parameter int REG_W = 3,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic             id_rs_used,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_rt_used,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_is_load,
  input  logic             id_is_halt,
  input  logic             redirect,
  input  logic             mem_stall,
  input  logic             mem_done,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_adv,
  output logic             halted,
  output logic [CNT_W-1:0] hazard_cnt
);

  typedef enum logic [1:0] {RUN, MEMWAIT, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rg;
    logic             ld;
  } slot_t;

  state_t      state, state_nx;
  slot_t       ex_s, mem_s, wb_s;
  logic [1:0]  drain_cnt;
  logic        hazard;
  logic        issue;
  logic        cnt_inc;
  logic        eff_run;
  logic        unused_wb;

  // WB only matters for drain completion; its register/load fields are never consulted.
  assign unused_wb = ^{wb_s.rg, wb_s.ld};

  function automatic logic match(input logic [REG_W-1:0] r);
`ifdef FORWARD_EN
    match = ex_s.v & ex_s.ld & (ex_s.rg == r);
`else
    match = (ex_s.v & (ex_s.rg == r)) | (mem_s.v & (mem_s.rg == r));
`endif
  endfunction

  assign hazard  = id_valid & ((id_rs_used & match(id_rs)) | (id_rt_used & match(id_rt)));
  assign eff_run = (state == RUN) | ((state == MEMWAIT) & mem_done & ~mem_stall);
  assign halted  = (state == HALTED);

  always_comb begin
    state_nx    = state;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    pipe_adv    = 1'b0;
    issue       = 1'b0;
    cnt_inc     = 1'b0;
    if (eff_run) begin
      state_nx = RUN;
      if (mem_stall) begin
        state_nx = MEMWAIT;
      end else if (redirect) begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
        pipe_adv    = 1'b1;
      end else if (hazard) begin
        idex_bubble = 1'b1;
        pipe_adv    = 1'b1;
        cnt_inc     = 1'b1;
      end else begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        pipe_adv = 1'b1;
        issue    = id_valid;
        if (id_valid & id_is_halt) state_nx = DRAIN;
      end
    end else if (state == DRAIN) begin
      if (!mem_stall) begin
        idex_bubble = 1'b1;
        pipe_adv    = 1'b1;
        // Third advance pushes the halt out of WB; EX and MEM must already be bubbles.
        if ((drain_cnt == 2'd2) && !ex_s.v && !mem_s.v) state_nx = HALTED;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= RUN;
      ex_s       <= '0;
      mem_s      <= '0;
      wb_s       <= '0;
      drain_cnt  <= '0;
      hazard_cnt <= '0;
    end else begin
      state <= state_nx;
      if (pipe_adv) begin
        wb_s  <= mem_s;
        mem_s <= ex_s;
        ex_s  <= issue ? slot_t'{v: id_wr_en, rg: id_wr_reg, ld: id_is_load} : slot_t'('0);
      end
      if (state != DRAIN)  drain_cnt <= '0;
      else if (pipe_adv)   drain_cnt <= drain_cnt + 2'd1;
      if (cnt_inc && !(&hazard_cnt)) hazard_cnt <= hazard_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  localparam int REG_W = 3;
  localparam int CNT_W = 16;
`ifdef FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid, id_rs_used, id_rt_used, id_wr_en, id_is_load, id_is_halt;
  logic [REG_W-1:0] id_rs, id_rt, id_wr_reg;
  logic             redirect, mem_stall, mem_done;
  logic             pc_en, ifid_en, ifid_flush, idex_bubble, pipe_adv, halted;
  logic [CNT_W-1:0] hazard_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .id_rt(id_rt), .id_rt_used(id_rt_used),
    .id_wr_en(id_wr_en), .id_wr_reg(id_wr_reg),
    .id_is_load(id_is_load), .id_is_halt(id_is_halt),
    .redirect(redirect), .mem_stall(mem_stall), .mem_done(mem_done),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
    .idex_bubble(idex_bubble), .pipe_adv(pipe_adv),
    .halted(halted), .hazard_cnt(hazard_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_ctl(input string tag, input logic pc, input logic ifid,
                           input logic flush, input logic bub, input logic adv);
    check_eq({tag, ".pc_en"},       pc_en,       pc);
    check_eq({tag, ".ifid_en"},     ifid_en,     ifid);
    check_eq({tag, ".ifid_flush"},  ifid_flush,  flush);
    check_eq({tag, ".idex_bubble"}, idex_bubble, bub);
    check_eq({tag, ".pipe_adv"},    pipe_adv,    adv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_id();
    id_valid = 0; id_rs = 0; id_rs_used = 0; id_rt = 0; id_rt_used = 0;
    id_wr_en = 0; id_wr_reg = 0; id_is_load = 0; id_is_halt = 0;
  endtask

  task automatic set_op(input logic [2:0] rs, input logic rs_u, input logic [2:0] rt, input logic rt_u,
                        input logic wr, input logic [2:0] wd, input logic ld, input logic hlt);
    id_valid = 1; id_rs = rs; id_rs_used = rs_u; id_rt = rt; id_rt_used = rt_u;
    id_wr_en = wr; id_wr_reg = wd; id_is_load = ld; id_is_halt = hlt;
  endtask

  task automatic drain_slots();
    idle_id();
    repeat (3) tick();
  endtask

  // producer writes r1, consumer SUB r2 <- r1 - r3
  task automatic run_dep(input string tag, input logic prod_ld, input int stalls);
    set_op(3'd2, 1, 3'd3, 1, 1, 3'd1, prod_ld, 0);
    #1 check_ctl({tag, ".prod"}, 1, 1, 0, 0, 1);
    tick();
    set_op(3'd1, 1, 3'd3, 1, 1, 3'd2, 0, 0);
    for (int i = 0; i < stalls; i++) begin
      #1 check_ctl($sformatf("%s.stall%0d", tag, i), 0, 0, 0, 1, 1);
      tick();
    end
    #1 check_ctl({tag, ".issue"}, 1, 1, 0, 0, 1);
    tick();
    idle_id();
    exp_cnt += stalls;
    #1 check_eq({tag, ".hazard_cnt"}, hazard_cnt, exp_cnt);
    drain_slots();
  endtask

  initial begin
    rst = 1; redirect = 0; mem_stall = 0; mem_done = 0;
    idle_id();
    #3 rst = 0;
    #1;
    check_ctl("reset", 1, 1, 0, 0, 1);
    check_eq("reset.halted", halted, 0);
    check_eq("reset.hazard_cnt", hazard_cnt, 0);
    tick();
    tick();
    rst = 1;

    // independent ADDs
    set_op(3'd2, 1, 3'd3, 1, 1, 3'd1, 0, 0);
    #1 check_ctl("indep.a", 1, 1, 0, 0, 1);
    tick();
    set_op(3'd5, 1, 3'd6, 1, 1, 3'd4, 0, 0);
    #1 check_ctl("indep.b", 1, 1, 0, 0, 1);
    tick();
    idle_id();
    #1 check_eq("indep.hazard_cnt", hazard_cnt, 0);
    drain_slots();

    run_dep("alu_dep", 1'b0, FWD ? 0 : 2);
    run_dep("load_use", 1'b1, FWD ? 1 : 2);

    // hazard and redirect in the same cycle (load producer stalls in either build)
    set_op(3'd2, 1, 3'd0, 0, 1, 3'd3, 1, 0);
    tick();
    set_op(3'd3, 1, 3'd0, 0, 1, 3'd4, 0, 0);
    redirect = 1;
    #1 check_ctl("redir_haz", 1, 1, 1, 1, 1);
    tick();
    redirect = 0;
    idle_id();
    #1 check_ctl("redir_after", 1, 1, 0, 0, 1);
    check_eq("redir.hazard_cnt", hazard_cnt, exp_cnt);
    drain_slots();

    // memory stall in the middle of a RAW stall
    set_op(3'd1, 1, 3'd0, 0, 1, 3'd5, 1, 0);
    tick();
    set_op(3'd5, 1, 3'd2, 1, 1, 3'd6, 0, 0);
    #1 check_ctl("mstall.first", 0, 0, 0, 1, 1);
    tick();
    exp_cnt += 1;
    mem_stall = 1;
    for (int i = 0; i < 4; i++) begin
      #1 check_ctl($sformatf("mstall.frozen%0d", i), 0, 0, 0, 0, 0);
      tick();
    end
    check_eq("mstall.hazard_cnt", hazard_cnt, exp_cnt);
    mem_stall = 0;
    mem_done  = 1;
    for (int i = 0; i < (FWD ? 0 : 1); i++) begin
      #1 check_ctl("mstall.remain", 0, 0, 0, 1, 1);
      tick();
      mem_done = 0;
      exp_cnt += 1;
    end
    #1 check_ctl("mstall.issue", 1, 1, 0, 0, 1);
    tick();
    mem_done = 0;
    idle_id();
    #1 check_eq("mstall.hazard_cnt_end", hazard_cnt, exp_cnt);
    drain_slots();

    // halt drain; redirect during drain must be ignored
    set_op(3'd1, 1, 3'd2, 1, 1, 3'd6, 0, 0);
    tick();
    set_op(3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 1);
    #1 check_ctl("halt.issue", 1, 1, 0, 0, 1);
    tick();
    idle_id();
    for (int i = 0; i < 3; i++) begin
      redirect = (i == 1);
      #1 check_ctl($sformatf("drain%0d", i), 0, 0, 0, 1, 1);
      check_eq($sformatf("drain%0d.halted", i), halted, 0);
      tick();
      redirect = 0;
    end
    check_eq("halted.set", halted, 1);
    check_ctl("halted.ctl", 0, 0, 0, 0, 0);
    tick();
    tick();
    check_eq("halted.sticky", halted, 1);

    // reset out of HALTED, then reset in the middle of a drain
    rst = 0;
    #1 check_eq("rst_halted.halted", halted, 0);
    tick();
    rst = 1;
    exp_cnt = 0;
    set_op(3'd1, 1, 3'd2, 1, 1, 3'd6, 0, 0);
    tick();
    set_op(3'd0, 0, 3'd0, 0, 0, 3'd0, 0, 1);
    tick();
    idle_id();
    #1 check_ctl("drain2", 0, 0, 0, 1, 1);
    #1 rst = 0;
    #1;
    check_eq("rst_drain.halted", halted, 0);
    check_ctl("rst_drain", 1, 1, 0, 0, 1);
    check_eq("rst_drain.hazard_cnt", hazard_cnt, 0);
    #1 rst = 1;
    set_op(3'd6, 1, 3'd6, 1, 1, 3'd2, 0, 0);
    #1 check_ctl("rst_drain.cleared", 1, 1, 0, 0, 1);
    tick();
    idle_id();
    #1 check_eq("rst_drain.halted_after", halted, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
